// File: rtl/inst_seq.sv
// inst_seq: instruction sequencer FSM.
// States run IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> WB and then back to
// FETCH or IDLE. All strobes are decoded from the registered state only.
// Optional feature: define INST_SEQ_TIMEOUT_EN to add an 8-bit wait counter
// that aborts a stalled FETCH or load with the sticky MEM_ERR flag.
module inst_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic        FETCH_READY,
   input  logic [1:0]  MEM_OP,
   input  logic        WRITE_ENB,
   input  logic        READ_READY,
   output logic        FETCH_REQ,
   output logic        INST_ENB,
   output logic        LSU_REQ,
   output logic        REG_WE,
   output logic        PC_CLK,
   output logic        BUSY,
   output logic [2:0]  STATE,
   output logic [31:0] INST_CNT,
   output logic        MEM_ERR
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [1:0] OP_STORE = 2'd1;
   localparam logic [1:0] OP_LOAD  = 2'd2;

   // The wait limit must fit the 8-bit counter and allow at least one retry.
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("inst_seq: TIMEOUT_CYCLES out of range 2..255");
   end

   state_t      state_q, state_nxt;
   logic [1:0]  mem_op_q;
   logic        we_q;
   logic [31:0] inst_cnt_q;
   logic        tmo;        // wait limit reached in this cycle

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   // Capture the decoder's memory op and write request at the end of EXEC.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mem_op_q <= 2'd0;
         we_q     <= 1'b0;
      end else if (state_q == S_EXEC) begin
         mem_op_q <= MEM_OP;
         we_q     <= WRITE_ENB;
      end
   end

   // Retired-instruction counter; bumps on the edge that leaves WB.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                inst_cnt_q <= 32'd0;
      else if (state_q == S_WB)  inst_cnt_q <= inst_cnt_q + 32'd1;
   end

   // Next-state and Moore strobe decode.
   always_comb begin
      state_nxt = state_q;
      FETCH_REQ = 1'b0;
      INST_ENB  = 1'b0;
      LSU_REQ   = 1'b0;
      REG_WE    = 1'b0;
      PC_CLK    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            FETCH_REQ = 1'b1;
            if (FETCH_READY) state_nxt = S_DECODE;
            else if (tmo)    state_nxt = S_IDLE;
         end
         S_DECODE: begin
            INST_ENB  = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            // Op code 3 is treated as no memory access.
            if (MEM_OP == OP_STORE || MEM_OP == OP_LOAD) state_nxt = S_MEM;
            else                                        state_nxt = S_WB;
         end
         S_MEM: begin
            LSU_REQ = 1'b1;
            if (mem_op_q != OP_LOAD) state_nxt = S_WB;
            else if (READ_READY)     state_nxt = S_WB;
            else if (tmo)            state_nxt = S_IDLE;
         end
         S_WB: begin
            PC_CLK    = 1'b1;
            REG_WE    = we_q;
            state_nxt = START ? S_FETCH : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef INST_SEQ_TIMEOUT_EN
   logic [7:0] wait_cnt_q;
   logic       waiting;
   logic       mem_err_q;

   assign waiting = (state_q == S_FETCH && !FETCH_READY) ||
                    (state_q == S_MEM && mem_op_q == OP_LOAD && !READ_READY);
   assign tmo     = waiting && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

   // Stall counter; restarts on every state change so each wait is timed alone.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                      wait_cnt_q <= 8'd0;
      else if (state_nxt != state_q)   wait_cnt_q <= 8'd0;
      else if (waiting)                wait_cnt_q <= wait_cnt_q + 8'd1;
   end

   // Sticky error: set on a timeout abort, cleared when the next fetch begins.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                                          mem_err_q <= 1'b0;
      else if (tmo)                                        mem_err_q <= 1'b1;
      else if (state_q == S_IDLE && state_nxt == S_FETCH)  mem_err_q <= 1'b0;
   end

   assign MEM_ERR = mem_err_q;
`else
   assign tmo     = 1'b0;
   assign MEM_ERR = 1'b0;
`endif

   assign BUSY     = (state_q != S_IDLE);
   assign STATE    = state_q;
   assign INST_CNT = inst_cnt_q;

endmodule
